// File: rtl/serial_frame_parity_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_parity_ctrl_if
//  Brief    : Bit-strobe / serial-line inputs and word-level result outputs
//             of the framed serial receive controller.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_frame_parity_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 bit_en;
    logic                 serial_data;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;
    logic                 parity_run;

    // Line-side driver: supplies the strobe and serial line, observes results
    modport master (
        output bit_en,
        output serial_data,
        input  data_out,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy,
        input  parity_run
    );

    // Receive controller
    modport slave (
        input  bit_en,
        input  serial_data,
        output data_out,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy,
        output parity_run
    );
endinterface
`default_nettype wire

// File: rtl/serial_frame_parity_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_frame_parity_ctrl
//  Brief    : Receive-side controller for a framed serial line:
//             start(0), DATA_BITS data bits LSB first, parity, stop(1).
//             Deserialises the word, checks parity and stop, and presents
//             the word plus error flags with a one-cycle valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module serial_frame_parity_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  wire logic                    clock,
    input  wire logic                    reset_n,
    serial_frame_parity_ctrl_if.slave    bus
);

    localparam int                 CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t                state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [DATA_BITS-1:0]  shift_q,      shift_d;
    logic                  acc_q,        acc_d;
    logic                  perr_q,       perr_d;
    logic [DATA_BITS-1:0]  data_out_q,   data_out_d;
    logic                  parity_err_q, parity_err_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  valid_q,      valid_d;
    // Set after a low stop bit: a line stuck low must be seen high once
    // before another start bit is accepted, so a held break does not
    // spawn a string of bogus frames.
    logic                  wait_high_q,  wait_high_d;

    // Next-state and datapath updates; nothing advances without a bit strobe
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        acc_d        = acc_q;
        perr_d       = perr_q;
        data_out_d   = data_out_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        valid_d      = 1'b0;
        wait_high_d  = wait_high_q;

        if (bus.bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (wait_high_q) begin
                        if (bus.serial_data) begin
                            wait_high_d = 1'b0;
                        end
                    end else if (!bus.serial_data) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        acc_d   = 1'b0;
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shift_d[i] = bus.serial_data;
                        end
                    end
                    acc_d = acc_q ^ bus.serial_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    perr_d  = acc_q ^ bus.serial_data ^ PARITY_ODD;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    // Errors are reported, never used to suppress the update
                    data_out_d   = shift_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ~bus.serial_data;
                    valid_d      = 1'b1;
                    wait_high_d  = ~bus.serial_data;
                    state_d      = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset; a partial frame is dropped
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            acc_q        <= 1'b0;
            perr_q       <= 1'b0;
            data_out_q   <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            valid_q      <= 1'b0;
            wait_high_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            acc_q        <= acc_d;
            perr_q       <= perr_d;
            data_out_q   <= data_out_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            valid_q      <= valid_d;
            wait_high_q  <= wait_high_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.parity_run = acc_q;

endmodule
`default_nettype wire
